// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: depth derivation, parameter legality and pointer distance.
package fifo_pkg;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic bit fifo_params_ok(input int addr_w, input int afull_th, input int aempty_th);
        return (afull_th >= 1) && (afull_th <= fifo_depth(addr_w)) &&
               (aempty_th >= 0) && (aempty_th <= fifo_depth(addr_w) - 1);
    endfunction

    // Pointers carry one extra wrap bit, so the distance is taken modulo 2**(addr_w+1).
    function automatic logic [31:0] ptr_distance(input logic [31:0] wptr, input logic [31:0] rptr,
                                                 input int addr_w);
        logic [31:0] mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with selectable registered or first-word-fall-through read, fill count,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              winc,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rinc,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              wfull,
    output logic              rempty,
    output logic              walmost_full,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   fill_cnt,
    output logic              overflow,
    output logic              underflow
);

    if (!fifo_params_ok(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_param_err
        $fatal(1, "sync_fifo_param: AFULL_TH or AEMPTY_TH out of range");
    end

    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AFULL_V   = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_V  = (ADDR_W + 1)'(AEMPTY_TH);

    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign rempty        = (wptr_q == rptr_q);
    assign wfull         = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                           (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign fill_cnt      = (ADDR_W + 1)'(ptr_distance(32'(wptr_q), 32'(rptr_q), ADDR_W));
    assign walmost_full  = (fill_cnt >= AFULL_V);
    assign ralmost_empty = (fill_cnt <= AEMPTY_V);
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

    // Acceptance uses pre-edge flags; flush drops both accesses silently.
    assign wr_acc = winc && !wfull && !flush;
    assign rd_acc = rinc && !rempty && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (wr_acc)         wptr_d = wptr_q + PTR_ONE;
            if (rd_acc)         rptr_d = rptr_q + PTR_ONE;
            if (winc && wfull)  ovf_d  = 1'b1;
            if (rinc && rempty) udf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Forced to zero while empty so reset and flush present a clean bus.
        assign rd_data = rempty ? '0 : mem_rdata;
    end else begin : g_reg_read
        logic [DATA_W-1:0] rd_q, rd_d;

        assign rd_d = rd_acc ? mem_rdata : rd_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance checked by a read scoreboard,
// plus a first-word-fall-through instance with hand-written expectations.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_winc, a_rinc, a_flush;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_wfull, a_rempty, a_walmost_full, a_ralmost_empty, a_overflow, a_underflow;
    logic [4:0] a_fill_cnt;

    logic       b_winc, b_rinc, b_flush;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_wfull, b_rempty, b_walmost_full, b_ralmost_empty, b_overflow, b_underflow;
    logic [4:0] b_fill_cnt;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) dut_reg (
        .clk(clk), .rst_n(rst_n), .winc(a_winc), .wr_data(a_wr_data), .rinc(a_rinc),
        .flush(a_flush), .rd_data(a_rd_data), .wfull(a_wfull), .rempty(a_rempty),
        .walmost_full(a_walmost_full), .ralmost_empty(a_ralmost_empty), .fill_cnt(a_fill_cnt),
        .overflow(a_overflow), .underflow(a_underflow)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .winc(b_winc), .wr_data(b_wr_data), .rinc(b_rinc),
        .flush(b_flush), .rd_data(b_rd_data), .wfull(b_wfull), .rempty(b_rempty),
        .walmost_full(b_walmost_full), .ralmost_empty(b_ralmost_empty), .fill_cnt(b_fill_cnt),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];
    bit         m_ovf, m_udf;
    bit         rd_pend;
    logic [7:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_data"}, a_rd_data, 0);
        chk({tag, "_fill_cnt"}, a_fill_cnt, 0);
        chk({tag, "_wfull"}, a_wfull, 0);
        chk({tag, "_rempty"}, a_rempty, 1);
        chk({tag, "_walmost_full"}, a_walmost_full, 0);
        chk({tag, "_ralmost_empty"}, a_ralmost_empty, 1);
        chk({tag, "_overflow"}, a_overflow, 0);
        chk({tag, "_underflow"}, a_underflow, 0);
    endtask

    task automatic check_flags();
        int n;
        n = model_q.size();
        chk("fill_cnt", a_fill_cnt, n);
        chk("wfull", a_wfull, n == 16);
        chk("rempty", a_rempty, n == 0);
        chk("walmost_full", a_walmost_full, n >= 12);
        chk("ralmost_empty", a_ralmost_empty, n <= 2);
        chk("overflow", a_overflow, m_ovf);
        chk("underflow", a_underflow, m_udf);
        if (!rd_pend) chk("rd_hold", a_rd_data, last_rd);
    endtask

    // One clock of stimulus on the registered-read instance; the expected read word is queued.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f);
        bit wacc, racc;
        int n;
        @(negedge clk);
        a_winc = w; a_wr_data = d; a_rinc = r; a_flush = f;
        n = model_q.size();
        wacc = w && (n < 16) && !f;
        racc = r && (n > 0) && !f;
        rd_pend = racc;
        if (racc) exp_q.push_back(model_q[0]);
        @(posedge clk);
        if (f) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && n == 16) m_ovf = 1'b1;
            if (r && n == 0)  m_udf = 1'b1;
            if (racc) void'(model_q.pop_front());
            if (wacc) model_q.push_back(d);
        end
        #3;
        check_flags();
    endtask

    always @(posedge clk) begin
        logic [7:0] e;
        if (rd_pend) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_scoreboard actual=read_pending required=queued_word at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", a_rd_data, e);
                last_rd = e;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        a_winc = 0; a_rinc = 0; a_flush = 0; a_wr_data = '0;
        b_winc = 0; b_rinc = 0; b_flush = 0; b_wr_data = '0;
        m_ovf = 0; m_udf = 0; rd_pend = 0; last_rd = '0;
        #2;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_after_16", a_wfull, 1);

        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_fill_stays", a_fill_cnt, 16);
        chk("ovf_set", a_overflow, 1);

        repeat (16) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained_empty", a_rempty, 1);
        chk("ovf_sticky", a_overflow, 1);

        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", a_underflow, 1);
        chk("udf_rd_hold", a_rd_data, 8'd16);

        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("empty_both_fill", a_fill_cnt, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_both_data", a_rd_data, 8'h55);

        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_ovf_clr", a_overflow, 0);
        chk("flush_udf_clr", a_underflow, 0);

        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_both_fill", a_fill_cnt, 15);
        chk("full_both_ovf", a_overflow, 1);
        chk("full_both_head", a_rd_data, 8'h20);

        repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("seven_stored", a_fill_cnt, 7);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        chk("flush_fill", a_fill_cnt, 0);
        chk("flush_empty", a_rempty, 1);
        chk("flush_ovf", a_overflow, 0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("after_flush_word", a_rd_data, 8'h3C);

        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("async");
        model_q.delete();
        exp_q.delete();
        m_ovf = 0; m_udf = 0; rd_pend = 0; last_rd = '0;
        @(negedge clk);
        a_winc = 0;
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        chk("fwft_init_empty", b_rempty, 1);
        @(negedge clk);
        b_winc = 1; b_wr_data = 8'h11;
        @(posedge clk); #1;
        chk("fwft_first_word", b_rd_data, 8'h11);
        chk("fwft_not_empty", b_rempty, 0);
        @(negedge clk);
        b_wr_data = 8'h22;
        @(posedge clk); #1;
        chk("fwft_head_held", b_rd_data, 8'h11);
        chk("fwft_fill2", b_fill_cnt, 2);
        @(negedge clk);
        b_winc = 0; b_rinc = 1;
        @(posedge clk); #1;
        chk("fwft_pop_next", b_rd_data, 8'h22);
        chk("fwft_fill1", b_fill_cnt, 1);
        @(negedge clk);
        @(posedge clk); #1;
        chk("fwft_drained", b_rempty, 1);
        @(negedge clk);
        b_rinc = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
